multicycle_controller: RTL and testbench

Finite-state controller that sequences the shared multicycle MIPS datapath: a single memory, a single ALU, and the PC/IR/A/B/ALUOut registers. The decision layer is a registered state machine driven by the opcode. The block sits beside the datapath and replaces the single-cycle combinational controller. It decodes `op`/`funct` from the IR and emits per-cycle enables and mux selects, with an optional memory ready handshake.

---
 rtl/mips_pkg.sv | 96 +++++++++
 rtl/multicycle_controller_if.sv | 32 +++
 rtl/alu_decoder.sv | 35 +++
 rtl/multicycle_controller.sv | 99 +++++++++
 tb/tb_multicycle_controller.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared constants for the multicycle MIPS controller: opcodes, funct codes,
// ALU codes, state encoding and the per-state control word.
package mips_pkg;

  localparam int STATE_W = 4;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;
  localparam logic [5:0] F_SLT = 6'h2A;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] ALUOP_NONE  = 2'b00;
  localparam logic [1:0] ALUOP_ADD   = 2'b01;
  localparam logic [1:0] ALUOP_SUB   = 2'b10;
  localparam logic [1:0] ALUOP_FUNCT = 2'b11;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       iord;
    logic       pc_write;
    logic       branch;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] aluop;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
  } ctrl_t;

  function automatic ctrl_t state_ctrl(input state_t s);
    ctrl_t c;
    c       = '0;
    c.aluop = ALUOP_ADD;
    case (s)
      S_FETCH:   begin c.mem_req = 1'b1; c.alu_src_b = 2'b01; end
      S_DECODE:  c.alu_src_b = 2'b11;
      S_MEMADR,
      S_ADDIEX:  begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      S_MEMRD:   begin c.mem_req = 1'b1; c.iord = 1'b1; end
      S_MEMWB:   begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; end
      S_MEMWR:   begin c.mem_req = 1'b1; c.mem_write = 1'b1; c.iord = 1'b1; end
      S_EXECUTE: begin c.alu_src_a = 1'b1; c.aluop = ALUOP_FUNCT; end
      S_ALUWB:   begin c.reg_write = 1'b1; c.reg_dst = 1'b1; end
      S_BRANCH:  begin
        c.alu_src_a = 1'b1;
        c.aluop     = ALUOP_SUB;
        c.pc_src    = 2'b01;
        c.branch    = 1'b1;
      end
      S_ADDIWB:  c.reg_write = 1'b1;
      S_JUMP:    begin c.pc_src = 2'b10; c.pc_write = 1'b1; end
      default:   c = '0;
    endcase
    return c;
  endfunction

  // Reset parks the selects on their FETCH values with no request outstanding.
  function automatic ctrl_t reset_ctrl();
    ctrl_t c;
    c         = state_ctrl(S_FETCH);
    c.mem_req = 1'b0;
    return c;
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath bundle: IR fields and flags in, enables and selects out.
interface multicycle_controller_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       mem_req;
  logic       mem_write;
  logic       iord;
  logic       ir_write;
  logic       pc_en;
  logic [1:0] pc_src;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alucontrol;
  logic       reg_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       illegal_op;

  modport master (
    input  op, funct, zero, mem_ready,
    output mem_req, mem_write, iord, ir_write, pc_en, pc_src, alu_src_a,
           alu_src_b, alucontrol, reg_write, reg_dst, mem_to_reg, illegal_op
  );

  modport slave (
    output op, funct, zero, mem_ready,
    input  mem_req, mem_write, iord, ir_write, pc_en, pc_src, alu_src_a,
           alu_src_b, alucontrol, reg_write, reg_dst, mem_to_reg, illegal_op
  );
endinterface

// File: rtl/alu_decoder.sv
// Combinational ALU control: aluop selects add/sub/idle or decodes funct,
// flagging funct values outside the supported set.
module alu_decoder
  import mips_pkg::*;
(
  input  logic [1:0] i_aluop,
  input  logic [5:0] i_funct,
  output logic [2:0] o_alucontrol,
  output logic       o_funct_illegal
);

  always_comb begin
    o_alucontrol    = ALU_AND;
    o_funct_illegal = 1'b0;
    case (i_aluop)
      ALUOP_ADD: o_alucontrol = ALU_ADD;
      ALUOP_SUB: o_alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (i_funct)
          F_ADD:   o_alucontrol = ALU_ADD;
          F_SUB:   o_alucontrol = ALU_SUB;
          F_AND:   o_alucontrol = ALU_AND;
          F_OR:    o_alucontrol = ALU_OR;
          F_SLT:   o_alucontrol = ALU_SLT;
          default: begin
            o_alucontrol    = ALU_ADD;
            o_funct_illegal = 1'b1;
          end
        endcase
      end
      default: o_alucontrol = ALU_AND;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle MIPS FSM controller; Moore control word registered from next state.
// CPI lw 5, sw/R/addi 4, beq/j 3, illegal 2; each low mem_ready cycle in a memory state adds 1.
// MULTICYCLE_MEM_HANDSHAKE_EN enables mem_ready stalls; otherwise memory is assumed always ready.
module multicycle_controller
  import mips_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset_n,
  multicycle_controller_if.master bus
);

  state_t     r_state;
  state_t     w_next;
  ctrl_t      r_ctrl;
  ctrl_t      w_ctrl;
  logic       w_ready;
  logic       w_bad_state;
  logic       w_fetch_go;
  logic       w_op_illegal;
  logic       w_funct_illegal;
  logic [2:0] w_alucontrol;

`ifdef MULTICYCLE_MEM_HANDSHAKE_EN
  assign w_ready = bus.mem_ready;
`else
  logic w_unused_mem_ready;
  assign w_unused_mem_ready = bus.mem_ready;
  assign w_ready            = 1'b1;
`endif

  // Encodings 12-15 are dead; silence every output if one is ever reached.
  assign w_bad_state = (r_state > S_JUMP);
  assign w_ctrl      = w_bad_state ? '0 : r_ctrl;

  // mem_req is low in the first cycle after reset, which keeps FETCH idle there.
  assign w_fetch_go  = (r_state == S_FETCH) && w_ctrl.mem_req && w_ready;

  always_comb begin
    case (bus.op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: w_op_illegal = 1'b0;
      default:                                        w_op_illegal = 1'b1;
    endcase
  end

  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:  w_next = w_fetch_go ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (bus.op)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_RTYPE:     w_next = S_EXECUTE;
          OP_BEQ:       w_next = S_BRANCH;
          OP_ADDI:      w_next = S_ADDIEX;
          OP_J:         w_next = S_JUMP;
          default:      w_next = S_FETCH;
        endcase
      end
      S_MEMADR:  w_next = (bus.op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   w_next = w_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:   w_next = w_ready ? S_FETCH : S_MEMWR;
      S_EXECUTE: w_next = S_ALUWB;
      S_ADDIEX:  w_next = S_ADDIWB;
      default:   w_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_FETCH;
      r_ctrl  <= reset_ctrl();
    end else begin
      r_state <= w_next;
      r_ctrl  <= state_ctrl(w_next);
    end
  end

  alu_decoder u_alu_decoder (
    .i_aluop         (w_ctrl.aluop),
    .i_funct         (bus.funct),
    .o_alucontrol    (w_alucontrol),
    .o_funct_illegal (w_funct_illegal)
  );

  assign bus.mem_req    = w_ctrl.mem_req;
  assign bus.mem_write  = w_ctrl.mem_write;
  assign bus.iord       = w_ctrl.iord;
  assign bus.ir_write   = w_fetch_go;
  assign bus.pc_en      = w_ctrl.pc_write | w_fetch_go | (w_ctrl.branch & bus.zero);
  assign bus.pc_src     = w_ctrl.pc_src;
  assign bus.alu_src_a  = w_ctrl.alu_src_a;
  assign bus.alu_src_b  = w_ctrl.alu_src_b;
  assign bus.alucontrol = w_alucontrol;
  assign bus.reg_write  = w_ctrl.reg_write;
  assign bus.reg_dst    = w_ctrl.reg_dst;
  assign bus.mem_to_reg = w_ctrl.mem_to_reg;
  assign bus.illegal_op = ((r_state == S_DECODE) && w_op_illegal) || w_funct_illegal;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed per-cycle vectors feed an expected-output queue; a negedge monitor
// pops and compares the full controller output word every pushed cycle.
module tb_multicycle_controller;

  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       iord;
    logic       ir_write;
    logic       pc_en;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alucontrol;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       illegal_op;
  } obs_t;

  localparam logic [5:0] LW = 6'h23, SW = 6'h2B, RT = 6'h00, BEQ = 6'h04;
  localparam logic [5:0] ADDI = 6'h08, JMP = 6'h02, BADOP = 6'h3F;
  localparam logic [5:0] FADD = 6'h20, FSLT = 6'h2A, FBAD = 6'h3F;

  //                             mr    mw    io    irw   pce   psrc   a     b      alu     rw    rd    m2r   ill
  localparam obs_t X_RST    = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b01, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam obs_t X_FGO    = {1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 2'b01, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam obs_t X_FWAIT  = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b01, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam obs_t X_DEC    = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b11, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam obs_t X_DECILL = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b11, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1};
  localparam obs_t X_MADR   = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 2'b10, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam obs_t X_MRD    = {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam obs_t X_MWB    = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 3'b010, 1'b1, 1'b0, 1'b1, 1'b0};
  localparam obs_t X_MWR    = {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam obs_t X_EXADD  = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 2'b00, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam obs_t X_EXSLT  = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 2'b00, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam obs_t X_EXILL  = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 2'b00, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1};
  localparam obs_t X_AWB    = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 3'b010, 1'b1, 1'b1, 1'b0, 1'b0};
  localparam obs_t X_BRT    = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 1'b1, 2'b00, 3'b110, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam obs_t X_BRN    = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1, 2'b00, 3'b110, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam obs_t X_AIEX   = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 2'b10, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam obs_t X_AIWB   = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 3'b010, 1'b1, 1'b0, 1'b0, 1'b0};
  localparam obs_t X_JMP    = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 2'b00, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0};

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;
  obs_t exp_q[$];
  string tag_q[$];
  obs_t obs;
  obs_t mon_e;
  string mon_t;

  multicycle_controller_if bus ();

  multicycle_controller dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  assign obs = {bus.mem_req, bus.mem_write, bus.iord, bus.ir_write, bus.pc_en, bus.pc_src,
                bus.alu_src_a, bus.alu_src_b, bus.alucontrol, bus.reg_write, bus.reg_dst,
                bus.mem_to_reg, bus.illegal_op};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      mon_t = tag_q.pop_front();
      checks = checks + 1;
      if (obs !== mon_e) begin
        errors = errors + 1;
        $display("FAIL %s: got %05h want %05h", mon_t, obs, mon_e);
      end
    end
  end

  // Drive one cycle's inputs just after the edge and queue that cycle's expectation.
  task automatic step(input logic [5:0] op, input logic [5:0] funct, input logic z,
                      input logic mr, input obs_t e, input string tag);
    bus.op        = op;
    bus.funct     = funct;
    bus.zero      = z;
    bus.mem_ready = mr;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    reset_n       = 1'b0;
    bus.op        = RT;
    bus.funct     = FADD;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b1;
    @(posedge clk);
    #1;

    step(RT, FADD, 1'b0, 1'b1, X_RST, "rst_hold0");
    step(RT, FADD, 1'b0, 1'b1, X_RST, "rst_hold1");
    reset_n = 1'b1;
    step(RT, FADD, 1'b0, 1'b1, X_RST, "rst_release_idle");

    step(RT, FADD, 1'b0, 1'b1, X_FGO,   "add_fetch");
    step(RT, FADD, 1'b0, 1'b1, X_DEC,   "add_decode");
    step(RT, FADD, 1'b0, 1'b1, X_EXADD, "add_execute");
    step(RT, FADD, 1'b0, 1'b1, X_AWB,   "add_aluwb");

    step(RT, FSLT, 1'b0, 1'b1, X_FGO,   "slt_fetch");
    step(RT, FSLT, 1'b0, 1'b1, X_DEC,   "slt_decode");
    step(RT, FSLT, 1'b0, 1'b1, X_EXSLT, "slt_execute");
    step(RT, FSLT, 1'b0, 1'b1, X_AWB,   "slt_aluwb");

    step(BEQ, FADD, 1'b1, 1'b1, X_FGO, "beqT_fetch");
    step(BEQ, FADD, 1'b1, 1'b1, X_DEC, "beqT_decode");
    step(BEQ, FADD, 1'b1, 1'b1, X_BRT, "beqT_branch");
    step(BEQ, FADD, 1'b0, 1'b1, X_FGO, "beqN_fetch");
    step(BEQ, FADD, 1'b0, 1'b1, X_DEC, "beqN_decode");
    step(BEQ, FADD, 1'b0, 1'b1, X_BRN, "beqN_branch");

    step(ADDI, FADD, 1'b0, 1'b1, X_FGO,  "addi_fetch");
    step(ADDI, FADD, 1'b0, 1'b1, X_DEC,  "addi_decode");
    step(ADDI, FADD, 1'b0, 1'b1, X_AIEX, "addi_ex");
    step(ADDI, FADD, 1'b0, 1'b1, X_AIWB, "addi_wb");

    step(JMP, FADD, 1'b1, 1'b1, X_FGO, "j_fetch");
    step(JMP, FADD, 1'b1, 1'b1, X_DEC, "j_decode");
    step(JMP, FADD, 1'b1, 1'b1, X_JMP, "j_jump");

    step(LW, FADD, 1'b0, 1'b1, X_FGO,  "lw_fetch");
    step(LW, FADD, 1'b0, 1'b1, X_DEC,  "lw_decode");
    step(LW, FADD, 1'b0, 1'b1, X_MADR, "lw_memadr");
    step(LW, FADD, 1'b0, 1'b1, X_MRD,  "lw_memrd");
    step(LW, FADD, 1'b0, 1'b1, X_MWB,  "lw_memwb");

    step(SW, FADD, 1'b0, 1'b1, X_FGO,  "sw_fetch");
    step(SW, FADD, 1'b0, 1'b1, X_DEC,  "sw_decode");
    step(SW, FADD, 1'b0, 1'b1, X_MADR, "sw_memadr");
    step(SW, FADD, 1'b0, 1'b1, X_MWR,  "sw_memwr");

    step(BADOP, FADD, 1'b0, 1'b1, X_FGO,    "illop_fetch");
    step(BADOP, FADD, 1'b0, 1'b1, X_DECILL, "illop_decode");

    step(RT, FBAD, 1'b0, 1'b1, X_FGO,   "illfn_fetch");
    step(RT, FBAD, 1'b0, 1'b1, X_DEC,   "illfn_decode");
    step(RT, FBAD, 1'b0, 1'b1, X_EXILL, "illfn_execute");
    step(RT, FBAD, 1'b0, 1'b1, X_AWB,   "illfn_aluwb");

`ifdef MULTICYCLE_MEM_HANDSHAKE_EN
    step(LW, FADD, 1'b0, 1'b0, X_FWAIT, "lwws_fetch_wait0");
    step(LW, FADD, 1'b0, 1'b0, X_FWAIT, "lwws_fetch_wait1");
    step(LW, FADD, 1'b0, 1'b1, X_FGO,   "lwws_fetch_go");
    step(LW, FADD, 1'b0, 1'b0, X_DEC,   "lwws_decode");
    step(LW, FADD, 1'b0, 1'b1, X_MADR,  "lwws_memadr");
    step(LW, FADD, 1'b0, 1'b0, X_MRD,   "lwws_memrd_wait");
    step(LW, FADD, 1'b0, 1'b1, X_MRD,   "lwws_memrd_go");
    step(LW, FADD, 1'b0, 1'b1, X_MWB,   "lwws_memwb");
`else
    step(SW, FADD, 1'b0, 1'b0, X_FGO,  "swnr_fetch");
    step(SW, FADD, 1'b0, 1'b0, X_DEC,  "swnr_decode");
    step(SW, FADD, 1'b0, 1'b0, X_MADR, "swnr_memadr");
    step(SW, FADD, 1'b0, 1'b0, X_MWR,  "swnr_memwr");
`endif

    step(LW, FADD, 1'b0, 1'b1, X_FGO,  "rstmid_fetch");
    step(LW, FADD, 1'b0, 1'b1, X_DEC,  "rstmid_decode");
    step(LW, FADD, 1'b0, 1'b1, X_MADR, "rstmid_memadr");
    reset_n = 1'b0;
    step(LW, FADD, 1'b0, 1'b1, X_RST, "rstmid_forced");
    step(LW, FADD, 1'b0, 1'b1, X_RST, "rstmid_hold");
    reset_n = 1'b1;
    step(LW, FADD, 1'b0, 1'b1, X_RST, "rstmid_idle");
    step(LW, FADD, 1'b0, 1'b1, X_FGO, "rstmid_first_req");
    step(LW, FADD, 1'b0, 1'b1, X_DEC, "rstmid_decode2");

    @(negedge clk);
    #1;
    checks = checks + 1;
    if (exp_q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL queue_drain: got %0d pending want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
